mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
//  Sequencer for an iterative 32x32 shift-and-add multiplier (MULT/MULTU) built on one shared Adder32.
//  Accepts a start pulse and sequences the adder for 32 iterations; returns the 64-bit product as HI/LO.
//  Sits beside the ALU in the execute stage; the pipeline stalls while busy=1.
// PARAMETERS
//  WIDTH      32  operand width; only 32 is legal (Adder32 is fixed-width); elaboration error otherwise
//  DONE_HOLD  0   0: done is a 1-cycle pulse; 1: done stays high until the next accepted start or reset
// PORTS
//  clk      in   1   single clock; all state updates on rising edge
//  reset_n  in   1   synchronous, active-low reset
//  start    in   1   request; sampled only when busy=0
//  op_a     in   32  multiplicand; sampled with start
//  op_b     in   32  multiplier; sampled with start
//  op_signed in  1   1=MULT (two's complement), 0=MULTU; present only with MULT_SIGNED_EN
//  busy     out  1   high from the cycle after start is accepted until the result is ready
//  done     out  1   result-valid strobe (see DONE_HOLD)
//  hi       out  32  product[63:32]; held stable from done until the next accepted start
//  lo       out  32  product[31:0]; same hold rule as hi
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0. A reset mid-operation
//    aborts the operation: no done, and the next cycle is IDLE.
//  - States: IDLE, [NEG_A, NEG_B], RUN, [FIX_LO, FIX_HI], DONE. Bracketed states exist only with MULT_SIGNED_EN.
//  - Start acceptance: start is accepted in IDLE or DONE. On acceptance, load mcand<=op_a, lo<=op_b, hi<=0,
//    cnt<=0, and enter RUN (or NEG_A when signed). start in any other state is ignored, with no queueing.
//  - RUN, one iteration per cycle: if lo[0], drive the adder with x=hi, y=mcand, cin=0, else y=0.
//    {hi,lo} <= {cout,sum,lo[31:1]} (shift right through the adder carry). cnt increments.
//  - RUN exit: leave RUN after exactly 32 iterations (cnt==31 at the edge). Adder overflow output is unused.
//  - Latency, unsigned: start accepted at edge E0; RUN occupies E1..E32; done=1 in the cycle after E32.
//    done is therefore observed 33 cycles after start.
//  - Latency, signed: always 37 cycles, fixed whatever the operand signs. Fix-up states are always traversed.
//  - Flag timing: busy=1 in every non-IDLE, non-DONE state. done is asserted only in DONE.
//  - DONE with DONE_HOLD=0: returns to IDLE after 1 cycle. With DONE_HOLD=1: stays in DONE until start.
//  - Simultaneous events: start in the DONE cycle is accepted, giving back-to-back operation.
//    In that case done=1 and busy=0 in that cycle, and busy=1 on the next.
//    reset_n=0 wins over start.
//  - Width rules: all arithmetic passes through the single adder instance, at most one add per cycle.
//    Product is exact modulo 2^64; there is no overflow signal.
// CONFIGURATION
//  Macro MULT_SIGNED_EN controls signed support.
//  Defined:
//  - The op_signed port exists.
//  - NEG_A: mcand <= |op_a| via adder (x=~a, y=0, cin=1 if a[31], else pass-through).
//  - NEG_B: lo <= |op_b| in the same way.
//  - neg_res = a[31]^b[31], latched at start.
//  - FIX_LO: lo <= ~lo+1 if neg_res; the carry is saved.
//  - FIX_HI: hi <= ~hi+carry if neg_res.
//  - op_signed=0 takes the same states as pass-throughs, so latency stays 37.
//  Undefined: no op_signed port; unsigned only; states skipped; latency 33.
// STRUCTURE
//  - Include file mult_defs.vh holds:
//    - state encodings MS_IDLE..MS_DONE (3-bit localparams);
//    - MULT_ITER=32;
//    - counter width 5.
//  - One sub-module: a single Adder32 instance (u_add) whose x/y/cin are muxed by state.
//    No further split; control and HI/LO/mcand registers live in this module.
// TESTING
//  T1: unsigned 3 x 5 -> done 33 cycles after start; hi=0x00000000, lo=0x0000000F.
//  T2: unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. busy high for exactly 32 cycles.
//  T3 (MULT_SIGNED_EN): signed -3 x 7 -> done at 37 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//     Also signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
//  T4: start pulsed on cycles 5 and 20 of a busy operation with new operands -> ignored.
//     Result equals the first operation; exactly one done.
//  T5: reset_n low for 1 cycle at RUN iteration 10 -> next cycle busy=0, done=0, hi=lo=0.
//     A fresh 2 x 2 then yields lo=4.
//  T6: start asserted in the DONE cycle (DONE_HOLD=0 and 1) -> second op accepted with no gap.
//     First result stays visible during that DONE cycle; second done follows 33 cycles later.

Source files
------------

// File: rtl/mult_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl_pkg
// Shared definitions for the iterative shift-and-add multiplier sequencer:
//   - ms_state_t : 3-bit FSM state encodings MS_IDLE..MS_DONE
//   - MULT_ITER  : number of shift-and-add iterations (one per operand bit)
//   - CNT_W      : iteration counter width
//   - last_iter(): true when the counter holds the final iteration index
// -----------------------------------------------------------------------------
package mult_seq_ctrl_pkg;

    localparam int MULT_ITER = 32;
    localparam int CNT_W     = 5;

    // NEG_A/NEG_B/FIX_LO/FIX_HI are only visited when MULT_SIGNED_EN is defined.
    typedef enum logic [2:0] {
        MS_IDLE   = 3'd0,
        MS_NEG_A  = 3'd1,
        MS_NEG_B  = 3'd2,
        MS_RUN    = 3'd3,
        MS_FIX_LO = 3'd4,
        MS_FIX_HI = 3'd5,
        MS_DONE   = 3'd6
    } ms_state_t;

    function automatic logic last_iter(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(MULT_ITER - 1);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_adder32.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl_adder32
// The single shared 32-bit adder used by the multiplier sequencer.
// Ports:
//   x, y  in  WIDTH  addends
//   cin   in  1      carry in
//   sum   out WIDTH  x + y + cin (low WIDTH bits)
//   cout  out 1      carry out
// -----------------------------------------------------------------------------
module mult_seq_ctrl_adder32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
// Sequencer for an iterative 32x32 shift-and-add multiplier (MULT/MULTU).
// All arithmetic goes through one shared adder (u_add), at most one add per
// cycle. Unsigned latency is 33 cycles from start to done; with signed support
// compiled in, latency is a fixed 37 cycles.
//
// Optional feature: define MULT_SIGNED_EN to add the op_signed port and the
// NEG_A/NEG_B/FIX_LO/FIX_HI states for two's-complement MULT.
//
// Parameters:
//   WIDTH      operand width, must be 32
//   DONE_HOLD  0: done is a 1-cycle pulse; 1: done held until next start/reset
// Ports:
//   clk        in   1      clock, rising edge
//   reset_n    in   1      synchronous active-low reset
//   start      in   1      request, sampled only in IDLE or DONE
//   op_a       in   WIDTH  multiplicand, sampled with start
//   op_b       in   WIDTH  multiplier, sampled with start
//   op_signed  in   1      1=MULT, 0=MULTU (MULT_SIGNED_EN only)
//   busy       out  1      operation in progress
//   done       out  1      result valid
//   hi         out  WIDTH  product[63:32]
//   lo         out  WIDTH  product[31:0]
// -----------------------------------------------------------------------------
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit DONE_HOLD = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef MULT_SIGNED_EN
    input  logic             op_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    if (WIDTH != 32) begin : g_bad_width
        $error("mult_seq_ctrl: WIDTH must be 32");
    end

    ms_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic               accept;

    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

`ifdef MULT_SIGNED_EN
    logic               is_signed;  // op_signed captured at start
    logic               neg_res;    // product must be negated at the end
    logic               fix_c;      // carry from negating lo, feeds hi
`endif

    assign accept = start && (state == MS_IDLE || state == MS_DONE);

    // Adder operand steering by state.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case
        // leaves a value unassigned and no latch is inferred.
        add_x   = hi;
        add_y   = '0;
        add_cin = 1'b0;
        case (state)
            MS_RUN: begin
                add_x = hi;
                add_y = lo[0] ? mcand : '0;
            end
`ifdef MULT_SIGNED_EN
            // Absolute value: ~v + 1 when negative, v + 0 otherwise.
            MS_NEG_A: begin
                add_x   = (is_signed && mcand[WIDTH-1]) ? ~mcand : mcand;
                add_cin = is_signed && mcand[WIDTH-1];
            end
            MS_NEG_B: begin
                add_x   = (is_signed && lo[WIDTH-1]) ? ~lo : lo;
                add_cin = is_signed && lo[WIDTH-1];
            end
            // 64-bit negate split over two adds; the low-half carry rides into hi.
            MS_FIX_LO: begin
                add_x   = neg_res ? ~lo : lo;
                add_cin = neg_res;
            end
            MS_FIX_HI: begin
                add_x   = neg_res ? ~hi : hi;
                add_cin = neg_res && fix_c;
            end
`endif
            default: ;
        endcase
    end

    mult_seq_ctrl_adder32 #(.WIDTH(WIDTH)) u_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the datapath registers are reset too because hi/lo are
            // visible outputs with a defined reset value of zero.
            state <= MS_IDLE;
            cnt   <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MULT_SIGNED_EN
            is_signed <= 1'b0;
            neg_res   <= 1'b0;
            fix_c     <= 1'b0;
`endif
        end else if (accept) begin
            mcand <= op_a;
            lo    <= op_b;
            hi    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef MULT_SIGNED_EN
            is_signed <= op_signed;
            neg_res   <= op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            state     <= MS_NEG_A;
`else
            state     <= MS_RUN;
`endif
        end else begin
            case (state)
                MS_IDLE: ;
                MS_RUN: begin
                    // Shift the partial product right through the adder carry.
                    {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                    if (last_iter(cnt)) begin
`ifdef MULT_SIGNED_EN
                        state <= MS_FIX_LO;
`else
                        state <= MS_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef MULT_SIGNED_EN
                MS_NEG_A: begin
                    mcand <= add_sum;
                    state <= MS_NEG_B;
                end
                MS_NEG_B: begin
                    lo    <= add_sum;
                    state <= MS_RUN;
                end
                MS_FIX_LO: begin
                    lo    <= add_sum;
                    fix_c <= add_cout;
                    state <= MS_FIX_HI;
                end
                MS_FIX_HI: begin
                    hi    <= add_sum;
                    state <= MS_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
`endif
                MS_DONE: begin
                    if (!DONE_HOLD) begin
                        state <= MS_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= MS_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
